// File: rtl/rk_video_pkg.sv
// Shared framebuffer geometry and clear-engine state encoding for the rk_video blocks.
// No logic; constants and types only.
// Consumers may override geometry through their own parameters.
package rk_video_pkg;

  localparam int FB_W    = 408;
  localparam int FB_H    = 300;
  localparam int FB_SIZE = FB_W * FB_H;
  localparam int ADDR_W  = 18;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

endpackage

// File: rtl/rk_fb_clear_engine.sv
// Clear engine: walks every framebuffer address once, writing 0, on a start pulse.
// Latency: first request one cycle after i_start; o_done one cycle after the last grant.
// Backpressure: the request stays up and the address holds while i_gnt is low.
module rk_fb_clear_engine
  import rk_video_pkg::*;
#(
  parameter int ADDR_W  = rk_video_pkg::ADDR_W,
  parameter int FB_SIZE = rk_video_pkg::FB_SIZE
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic              i_gnt,
  output logic              o_req,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_SIZE - 1);

  clr_state_t        r_state;
  clr_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              r_busy;
  logic              r_done;

  // Next state and address: a start is only honoured from IDLE, the address advances per grant.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = CLEAR;
          w_addr_nxt  = '0;
        end
      end
      CLEAR: begin
        if (i_gnt) begin
          if (r_addr == LAST_ADDR) begin
            w_state_nxt = DONE;
            w_addr_nxt  = '0;
          end else begin
            w_addr_nxt = r_addr + 1'b1;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register; busy/done are registered from the next state so they line up with it.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_busy  <= (w_state_nxt == CLEAR);
      r_done  <= (w_state_nxt == DONE);
    end
  end

  assign o_req  = (r_state == CLEAR);
  assign o_addr = r_addr;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: rtl/rk_fb_write_arb.sv
// Framebuffer port-A write arbiter: video > clear engine > host, one registered write per clock.
// Latency: a grant in cycle N drives o_fb_* and o_host_ack in cycle N+1.
// Backpressure: video is never stalled; clear waits for video-free cycles; host holds i_host_req until ack.
module rk_fb_write_arb
  import rk_video_pkg::*;
#(
  parameter int ADDR_W  = rk_video_pkg::ADDR_W,
  parameter int FB_W    = rk_video_pkg::FB_W,
  parameter int FB_H    = rk_video_pkg::FB_H,
  parameter int STALL_W = 16
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_vid_we,
  input  logic [ADDR_W-1:0]  i_vid_addr,
  input  logic               i_vid_data,
  input  logic               i_clr_start,
  output logic               o_clr_busy,
  output logic               o_clr_done,
  input  logic               i_host_req,
  input  logic [ADDR_W-1:0]  i_host_addr,
  input  logic               i_host_data,
  output logic               o_host_ack,
  output logic               o_fb_we,
  output logic [ADDR_W-1:0]  o_fb_addr,
  output logic               o_fb_data,
  output logic [STALL_W-1:0] o_stall_cnt
);

  localparam int                 FB_SIZE   = FB_W * FB_H;
  // One extra bit so a framebuffer that exactly fills the address space still compares correctly.
  localparam logic [ADDR_W:0]    FB_SIZE_X = (ADDR_W + 1)'(FB_SIZE);
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  logic               w_clr_req;
  logic [ADDR_W-1:0]  w_clr_addr;
  logic               w_clr_gnt;
  logic               w_host_gnt;
  logic               w_host_ok;
  logic               r_fb_we;
  logic [ADDR_W-1:0]  r_fb_addr;
  logic               r_fb_data;
  logic               r_host_ack;
  logic [STALL_W-1:0] r_stall;

  rk_fb_clear_engine #(
    .ADDR_W  (ADDR_W),
    .FB_SIZE (FB_SIZE)
  ) u_clear (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_start   (i_clr_start),
    .i_gnt     (w_clr_gnt),
    .o_req     (w_clr_req),
    .o_addr    (w_clr_addr),
    .o_busy    (o_clr_busy),
    .o_done    (o_clr_done)
  );

  // Fixed priority; the host is masked during its own ack cycle so one request is never granted twice.
  assign w_clr_gnt  = w_clr_req & ~i_vid_we;
  assign w_host_gnt = i_host_req & ~r_host_ack & ~i_vid_we & ~w_clr_req;
  assign w_host_ok  = ({1'b0, i_host_addr} < FB_SIZE_X);

  // Output write port: out-of-range host writes are acked but never reach the RAM.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_fb_we    <= 1'b0;
      r_fb_addr  <= '0;
      r_fb_data  <= 1'b0;
      r_host_ack <= 1'b0;
    end else begin
      r_fb_we    <= i_vid_we | w_clr_gnt | (w_host_gnt & w_host_ok);
      r_host_ack <= w_host_gnt;
      if (i_vid_we) begin
        r_fb_addr <= i_vid_addr;
        r_fb_data <= i_vid_data;
      end else if (w_clr_gnt) begin
        r_fb_addr <= w_clr_addr;
        r_fb_data <= 1'b0;
      end else if (w_host_gnt && w_host_ok) begin
        r_fb_addr <= i_host_addr;
        r_fb_data <= i_host_data;
      end
    end
  end

  // Saturating count of cycles the host waited; the ack cycle itself is not a wait.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_stall <= '0;
    end else if (i_host_req && !w_host_gnt && !r_host_ack && (r_stall != STALL_MAX)) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  assign o_fb_we     = r_fb_we;
  assign o_fb_addr   = r_fb_addr;
  assign o_fb_data   = r_fb_data;
  assign o_host_ack  = r_host_ack;
  assign o_stall_cnt = r_stall;

endmodule

// File: doc/rk_fb_write_arb.md
Name: rk_fb_write_arb

Overview:
- Arbitrates the single write port (port A) of the 408x300x1 video framebuffer between three requesters.
- Requesters, in priority order: the RK character renderer (pixel stream), a built-in clear engine, and a host/OSD pixel writer.
- Sits between the video renderer and the framebuffer RAM. The RAM write enable is no longer tied high; this block drives it.
- Output is one registered write per clock at most.

Parameters:
ADDR_W, 18, framebuffer address width
FB_W, 408, framebuffer width in pixels
FB_H, 300, framebuffer height in lines
STALL_W, 16, width of the host stall counter

Ports:
clk  in  1  system clock (48 MHz)
reset_n  in  1  asynchronous active-low reset
vid_we  in  1  renderer write strobe, at most one every 3 clk
vid_addr  in  ADDR_W  renderer pixel address
vid_data  in  1  renderer pixel value
clr_start  in  1  single-cycle pulse: fill framebuffer with 0
clr_busy  out  1  clear engine active
clr_done  out  1  single-cycle pulse when clear completes
host_req  in  1  host write request, held until host_ack
host_addr  in  ADDR_W  host pixel address
host_data  in  1  host pixel value
host_ack  out  1  single-cycle acknowledge
fb_we  out  1  framebuffer port A write enable
fb_addr  out  ADDR_W  framebuffer port A address
fb_data  out  1  framebuffer port A data
stall_cnt  out  STALL_W  saturating count of host-waiting cycles

Behaviour:
- Reset (async, reset_n=0): fb_we=0, fb_addr=0, fb_data=0, host_ack=0, clr_busy=0, clr_done=0, stall_cnt=0; FSM=IDLE; clear address=0. Reset mid-clear abandons the clear and does not emit clr_done.
- All outputs are registered. A grant in cycle N appears on fb_* and host_ack in cycle N+1.
- Fixed priority each cycle: vid_we > clear engine (state CLEAR) > host_req.
  - vid_we is never stalled. It always wins.
- Clear FSM states and transitions:
  - IDLE: on clr_start go to CLEAR; clear addr=0; clr_busy=1.
  - CLEAR: each cycle without vid_we, issue write addr=clear addr, data=0, then increment. A cycle with vid_we holds clear addr. When the write of addr FB_W*FB_H-1 (122399) is granted, go to DONE.
  - DONE: clr_done=1 for one cycle, clr_busy=0, return to IDLE.
  - clr_start during CLEAR or DONE is ignored.
  - clr_start coincident with vid_we: enter CLEAR anyway; the first clear write waits for a free cycle.
- Host handshake:
  - A request is granted in a cycle with no vid_we and FSM not CLEAR. host_ack pulses with the write.
  - After ack the host may present the next request in the following cycle. The arbiter ignores host_req while host_ack=1, so there is no double grant.
  - host_addr >= FB_W*FB_H: acked, fb_we=0, write dropped.
  - A host request is held off for the whole clear.
- No grant in a cycle: fb_we=0; fb_addr and fb_data hold their previous values.
- stall_cnt: +1 each cycle host_req=1 and host is not granted (excluding the ack cycle). Saturates at 2^STALL_W-1. Cleared only by reset.
- Arithmetic: FB size product is computed as a constant at elaboration and must fit ADDR_W. The clear address counter is ADDR_W wide.

Decomposition:
- Shared package rk_video_pkg holds:
  - FB_W, FB_H, FB_SIZE (=FB_W*FB_H), ADDR_W constants, reused by rk_video scan logic.
  - Clear FSM state encoding: IDLE=2'd0, CLEAR=2'd1, DONE=2'd2.
- One natural sub-module: rk_fb_clear_engine, containing the FSM, address counter, clr_busy/clr_done, and a request/grant pair toward the arbiter core. The priority mux, host handshake and stall counter stay in the top.

Test Plan:
- Reset, then vid_we pulses every 3 clk at addr 0,1,2 with data 1,0,1 -> fb_we high 1 clk after each pulse; fb_addr 0,1,2; fb_data 1,0,1; no other writes.
- host_req addr 1000 data 1 with no video traffic -> host_ack and fb_we at cycle+1 with fb_addr=1000, fb_data=1; stall_cnt=0.
- host_req coincident with vid_we -> video write first; host_ack one cycle later; stall_cnt=1.
- clr_start with vid_we every 3rd cycle -> exactly 122400 writes of data 0 covering addrs 0..122399 once each; clr_done pulses once; clr_busy falls with it; total duration about 183600 cycles.
- host_req held during clear -> no ack until the cycle after clr_done; stall_cnt equals waited cycles; host_req addr 122400 -> ack, fb_we=0.
- reset_n low mid-clear at addr 5000 -> outputs zero immediately; no clr_done; new clr_start restarts at addr 0.
